// File: rtl/transconv_seq_if.sv
// Bundle of handshake and datapath-control signals for the transposed
// convolution sequencer. The controller connects through the slave modport;
// whatever drives layers and pixels (and watches the datapath strobes)
// connects through the master modport.
// Optional feature macro: TRANSCONV_SEQ_PERF_EN adds the stall_cnt counter.

interface transconv_seq_if;

    logic        start;
    logic [7:0]  cfg_width;
    logic [7:0]  cfg_height;
    logic        in_valid;
    logic        in_ready;
    logic        dp_rw;
    logic        dp_hop;
    logic        dp_flip;
    logic [7:0]  dp_width;
    logic        out_valid;
    logic        busy;
    logic        done;
`ifdef TRANSCONV_SEQ_PERF_EN
    logic [15:0] stall_cnt;
`endif

`ifdef TRANSCONV_SEQ_PERF_EN
    modport master (
        output start, cfg_width, cfg_height, in_valid,
        input  in_ready, dp_rw, dp_hop, dp_flip, dp_width,
        input  out_valid, busy, done, stall_cnt
    );

    modport slave (
        input  start, cfg_width, cfg_height, in_valid,
        output in_ready, dp_rw, dp_hop, dp_flip, dp_width,
        output out_valid, busy, done, stall_cnt
    );
`else
    modport master (
        output start, cfg_width, cfg_height, in_valid,
        input  in_ready, dp_rw, dp_hop, dp_flip, dp_width,
        input  out_valid, busy, done
    );

    modport slave (
        input  start, cfg_width, cfg_height, in_valid,
        output in_ready, dp_rw, dp_hop, dp_flip, dp_width,
        output out_valid, busy, done
    );
`endif

endinterface

// File: rtl/transconv_seq.sv
// Layer sequencer for a transposed-convolution datapath with a ping-pong
// line buffer. Each input row is written into one half of the buffer
// (WRITE), then read back for 2*width cycles (READ) while the datapath
// upsamples it; after the last row one more 2*width read pass drains the
// pipeline (FLUSH). dp_flip swaps the buffer halves between rows.
// Optional feature macro: TRANSCONV_SEQ_PERF_EN adds a saturating count of
// WRITE cycles spent waiting for input pixels (stall_cnt).

module transconv_seq #(
    parameter int MAX_WIDTH = 128
) (
    input  logic           clk,
    input  logic           rst,
    transconv_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Widest row the line buffer can hold while still double-buffering.
    localparam logic [8:0] HALF_WIDTH = 9'(MAX_WIDTH / 2);

    state_t     state;
    state_t     state_n;

    logic [7:0] width_q;
    logic [7:0] height_q;
    logic [8:0] col_cnt;
    logic [8:0] row_cnt;
    logic [8:0] rd_cnt;
    logic       flip_q;
    logic       out_valid_q;

    logic [8:0] width_ext;
    logic [8:0] height_ext;
    logic [8:0] col_last;
    logic [8:0] rd_last;
    logic       cfg_ok;

    logic       start_accept;
    logic       pix_accept;
    logic       row_end;
    logic       rd_end;
    logic       flip_toggle;
    logic       ready_c;
    logic       rw_c;
    logic       hop_c;
    logic       done_c;

    assign width_ext  = {1'b0, width_q};
    assign height_ext = {1'b0, height_q};
    assign col_last   = width_ext - 9'd1;
    assign rd_last    = (width_ext << 1) - 9'd1;

    assign cfg_ok = (bus.cfg_width != 8'd0)
                 && ({1'b0, bus.cfg_width} <= HALF_WIDTH)
                 && (bus.cfg_height != 8'd0);

    // State register; reset drops any layer in progress without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode plus the combinational handshake and datapath strobes.
    always_comb begin
        state_n      = state;
        start_accept = 1'b0;
        pix_accept   = 1'b0;
        row_end      = 1'b0;
        rd_end       = 1'b0;
        flip_toggle  = 1'b0;
        ready_c      = 1'b0;
        rw_c         = 1'b0;
        hop_c        = 1'b0;
        done_c       = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start && cfg_ok) begin
                    start_accept = 1'b1;
                    state_n      = WRITE;
                end
            end

            WRITE: begin
                ready_c = 1'b1;
                rw_c    = bus.in_valid;
                hop_c   = bus.in_valid;
                if (bus.in_valid) begin
                    pix_accept = 1'b1;
                    if (col_cnt == col_last) begin
                        row_end = 1'b1;
                        state_n = READ;
                    end
                end
            end

            READ: begin
                if (rd_cnt == rd_last) begin
                    rd_end = 1'b1;
                    if (row_cnt == height_ext) begin
                        state_n = FLUSH;
                    end else begin
                        flip_toggle = 1'b1;
                        state_n     = WRITE;
                    end
                end
            end

            FLUSH: begin
                if (rd_cnt == rd_last) begin
                    rd_end      = 1'b1;
                    flip_toggle = 1'b1;
                    done_c      = 1'b1;
                    state_n     = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Layer configuration and the column/row/read counters that pace the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            width_q  <= 8'd0;
            height_q <= 8'd0;
            col_cnt  <= 9'd0;
            row_cnt  <= 9'd0;
            rd_cnt   <= 9'd0;
            flip_q   <= 1'b0;
        end else if (start_accept) begin
            width_q  <= bus.cfg_width;
            height_q <= bus.cfg_height;
            col_cnt  <= 9'd0;
            row_cnt  <= 9'd0;
            rd_cnt   <= 9'd0;
            flip_q   <= 1'b0;
        end else begin
            if (pix_accept) begin
                col_cnt <= row_end ? 9'd0 : col_cnt + 9'd1;
            end
            if (row_end) begin
                row_cnt <= row_cnt + 9'd1;
            end
            if ((state == READ) || (state == FLUSH)) begin
                rd_cnt <= rd_end ? 9'd0 : rd_cnt + 9'd1;
            end
            if (flip_toggle) begin
                flip_q <= ~flip_q;
            end
        end
    end

    // out_valid lags the read phases by one cycle to line up with the
    // registered pixel coming out of the datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= (state == READ) || (state == FLUSH);
        end
    end

`ifdef TRANSCONV_SEQ_PERF_EN
    logic [15:0] stall_q;

    // Counts WRITE cycles with no pixel offered; sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= 16'd0;
        end else if (start_accept) begin
            stall_q <= 16'd0;
        end else if ((state == WRITE) && !bus.in_valid && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_q;
`endif

    assign bus.in_ready  = ready_c;
    assign bus.dp_rw     = rw_c;
    assign bus.dp_hop    = hop_c;
    assign bus.dp_flip   = flip_q;
    assign bus.dp_width  = width_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_c;

endmodule

// File: tb/tb_transconv_seq.sv
// Self-checking bench for transconv_seq. A layer-level model turns the
// configured width/height and the in_valid pattern into expected totals
// (busy cycles, stalls, writes, out_valid beats, final buffer role) and a
// per-pixel buffer-role list; a monitor compares them as the DUT produces
// write strobes and done pulses.

module tb_transconv_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    transconv_seq_if bus ();

    transconv_seq #(.MAX_WIDTH(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int w;
        int h;
        int busy_cycles;
        int stalls;
        int writes;
        int outs;
        int final_flip;
    } layer_t;

    int     checks   = 0;
    int     failures = 0;
    bit     pat [4096];
    int     rstart [256];
    layer_t exp_q [$];
    bit     flip_q [$];

    // Shared comparison helper: one FAIL line per mismatch.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Fill the in_valid pattern: 0 = always valid, 1 = alternating, 2 = random.
    task automatic fillPattern(input int mode);
        for (int i = 0; i < 4096; i++) begin
            case (mode)
                0:       pat[i] = 1'b1;
                1:       pat[i] = (i % 2 == 0);
                default: pat[i] = ($urandom_range(0, 3) != 0);
            endcase
        end
    endtask

    // Layer model: walk the in_valid pattern row by row from the first WRITE cycle.
    function automatic layer_t modelLayer(input int w, input int h);
        layer_t L;
        int     t;
        int     ones;
        t        = 0;
        L.w      = w;
        L.h      = h;
        L.stalls = 0;
        for (int r = 0; r < h; r++) begin
            ones = 0;
            while (ones < w && t < 4096) begin
                if (pat[t]) ones++;
                else        L.stalls++;
                t++;
            end
            rstart[r] = t;
            t += 2 * w;
        end
        t += 2 * w;
        L.busy_cycles = t;
        L.writes      = w * h;
        L.outs        = 2 * w * (h + 1);
        L.final_flip  = h % 2;
        return L;
    endfunction

    task automatic checkResetOutputs(input string name);
        logic [14:0] v;
        v = {bus.in_ready, bus.dp_rw, bus.dp_hop, bus.dp_flip, bus.dp_width,
             bus.out_valid, bus.busy, bus.done};
        checkOutput(name, int'(v), 0);
`ifdef TRANSCONV_SEQ_PERF_EN
        checkOutput({name, "_stall_cnt"}, int'(bus.stall_cnt), 0);
`endif
    endtask

    // Run one layer; optionally pulse start during READ of inject_row or reset
    // during READ of abort_row.
    task automatic applyStimulus(input int w, input int h, input int inject_row, input int abort_row);
        layer_t L;
        int     k;
        int     inj_k;
        int     abt_k;
        L     = modelLayer(w, h);
        inj_k = (inject_row >= 0) ? rstart[inject_row] + 1 : -1;
        abt_k = (abort_row  >= 0) ? rstart[abort_row]  + 2 : -1;
        exp_q.push_back(L);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                flip_q.push_back(bit'(r % 2));

        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.cfg_width  = 8'(w);
        bus.cfg_height = 8'(h);
        bus.in_valid   = 1'b0;
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.cfg_width  = 8'($urandom);
        bus.cfg_height = 8'($urandom);
        checkOutput("busy_after_start", int'(bus.busy), 1);

        k = 0;
        while (1) begin
            bus.in_valid = pat[k];
            bus.start    = (k == inj_k);
            if (k == inj_k) begin
                bus.cfg_width  = 8'd5;
                bus.cfg_height = 8'd3;
            end
            if (k == abt_k) begin
                rst = 1'b0;
                #2;
                checkResetOutputs("abort_outputs");
                @(posedge clk); #1;
                rst = 1'b1;
                break;
            end
            @(posedge clk); #1;
            k++;
            if (!bus.busy) break;
            if (k >= 4000) begin
                checkOutput("layer_timeout", k, L.busy_cycles);
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (abt_k >= 0) checkOutput("idle_after_abort", int'(bus.busy), 0);
    endtask

    // Start requests that must be refused; no write strobe may follow.
    task automatic applyIllegal(input int w, input int h, input string name);
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.cfg_width  = 8'(w);
        bus.cfg_height = 8'(h);
        bus.in_valid   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checkOutput({name, "_busy"}, int'(bus.busy), 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput({name, "_busy_later"}, int'(bus.busy), 0);
        bus.in_valid = 1'b0;
    endtask

    int     busy_cnt  = 0;
    int     ready_cnt = 0;
    int     rw_cnt    = 0;
    int     hop_cnt   = 0;
    int     out_cnt   = 0;
    bit     post      = 1'b0;
    layer_t last;

    // Monitor: accumulate DUT activity and score it at each done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            flip_q.delete();
            busy_cnt  = 0;
            ready_cnt = 0;
            rw_cnt    = 0;
            hop_cnt   = 0;
            out_cnt   = 0;
            post      = 1'b0;
        end else begin
            if (bus.busy)      busy_cnt++;
            if (bus.in_ready)  ready_cnt++;
            if (bus.dp_hop)    hop_cnt++;
            if (bus.out_valid) out_cnt++;
            if (bus.dp_rw) begin
                rw_cnt++;
                if (flip_q.size() == 0 || exp_q.size() == 0) begin
                    checkOutput("unexpected_write", 1, 0);
                end else begin
                    checkOutput("write_flip", int'(bus.dp_flip), int'(flip_q.pop_front()));
                    checkOutput("write_width", int'(bus.dp_width), exp_q[0].w);
                end
            end
            if (post) begin
                checkOutput("out_valid_total", out_cnt, last.outs);
                checkOutput("idle_flip", int'(bus.dp_flip), last.final_flip);
                checkOutput("done_one_cycle", int'(bus.done), 0);
                checkOutput("idle_busy", int'(bus.busy), 0);
                out_cnt = 0;
                post    = 1'b0;
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    last = exp_q.pop_front();
                    checkOutput("busy_cycles", busy_cnt, last.busy_cycles);
                    checkOutput("write_beats", rw_cnt, last.writes);
                    checkOutput("hop_beats", hop_cnt, last.writes);
                    checkOutput("ready_cycles", ready_cnt, last.writes + last.stalls);
                    checkOutput("done_width", int'(bus.dp_width), last.w);
`ifdef TRANSCONV_SEQ_PERF_EN
                    checkOutput("stall_cnt", int'(bus.stall_cnt), last.stalls);
`endif
                    post = 1'b1;
                end
                busy_cnt  = 0;
                ready_cnt = 0;
                rw_cnt    = 0;
                hop_cnt   = 0;
            end
        end
    end

    // Main sequence of scenarios.
    initial begin
        bus.start      = 1'b1;
        bus.cfg_width  = 8'd4;
        bus.cfg_height = 8'd2;
        bus.in_valid   = 1'b0;
        rst            = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset_hold");
        bus.start = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;

        fillPattern(0);
        applyStimulus(4, 2, -1, -1);

        fillPattern(1);
        applyStimulus(3, 1, -1, -1);

        applyIllegal(0, 2, "illegal_w0");
        applyIllegal(65, 1, "illegal_w65");
        applyIllegal(4, 0, "illegal_h0");

        fillPattern(2);
        applyStimulus(64, 1, -1, -1);
        fillPattern(2);
        applyStimulus(1, 3, -1, -1);

        fillPattern(2);
        applyStimulus(5, 3, 0, -1);

        fillPattern(0);
        applyStimulus(4, 3, -1, 1);
        fillPattern(0);
        applyStimulus(2, 1, -1, -1);

        for (int i = 0; i < 5; i++) begin
            fillPattern(2);
            applyStimulus($urandom_range(1, 16), $urandom_range(1, 4), -1, -1);
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("leftover_expectations", exp_q.size() + flip_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall time bound in case the DUT wedges somewhere unexpected.
    initial begin
        #2000000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
